flip_alpha_gen: RTL and testbench

Chase-stage front end that scans one codeword's per-bit reliability magnitudes and locates the two least-reliable bit positions. It then produces the odd-power locator values alpha^j, alpha^3j, alpha^5j and alpha^7j for each position. It sits directly upstream of `flip_syndrome`: its `o_flip_alpha_*` outputs and `o_flip_alpha_valid` connect to that stage's `i_flip_alpha_*` inputs. Valid is held stable until released.

---
 rtl/flip_alpha_gen_pkg.sv | 48 ++++
 rtl/gf_mult.sv | 22 ++
 rtl/flip_alpha_gen.sv | 134 +++++++++++++
 tb/tb_flip_alpha_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/flip_alpha_gen_pkg.sv
// Shared field definitions for the Chase flip-position front end: code
// encodings, per-field lengths, primitive polynomials and the alpha-step helper.
package flip_alpha_gen_pkg;

  localparam logic [1:0] CODE_GF6  = 2'b00;
  localparam logic [1:0] CODE_GF8  = 2'b01;
  localparam logic [1:0] CODE_GF10 = 2'b10;

  localparam logic [9:0] N_GF6  = 10'd63;
  localparam logic [9:0] N_GF8  = 10'd255;
  localparam logic [9:0] N_GF10 = 10'd1023;

  localparam logic [10:0] POLY_GF6  = 11'h043;
  localparam logic [10:0] POLY_GF8  = 11'h11D;
  localparam logic [10:0] POLY_GF10 = 11'h409;

  typedef enum logic [1:0] {SCAN, POW, HOLD} state_t;

  function automatic logic [9:0] code_n(input logic [1:0] code);
    case (code)
      CODE_GF6: return N_GF6;
      CODE_GF8: return N_GF8;
      default:  return N_GF10;
    endcase
  endfunction

  // One LFSR step: x * alpha reduced by the selected primitive polynomial.
  function automatic logic [9:0] gf_mul_alpha(input logic [1:0] code, input logic [9:0] x);
    logic [10:0] s;
    s = {x, 1'b0};
    case (code)
      CODE_GF6: begin
        if (s[6]) s = s ^ POLY_GF6;
        s = s & 11'h03F;
      end
      CODE_GF8: begin
        if (s[8]) s = s ^ POLY_GF8;
        s = s & 11'h0FF;
      end
      default: begin
        if (s[10]) s = s ^ POLY_GF10;
        s = s & 11'h3FF;
      end
    endcase
    return s[9:0];
  endfunction

endpackage

// File: rtl/gf_mult.sv
// Combinational GF(2^m) multiplier over the field selected by code (Horner form).
module gf_mult
  import flip_alpha_gen_pkg::*;
(
  input  logic [1:0] code,
  input  logic [9:0] a,
  input  logic [9:0] b,
  output logic [9:0] p
);

  logic [9:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 9; i >= 0; i--) begin
      acc = gf_mul_alpha(code, acc);
      if (b[i]) acc = acc ^ a;
    end
    p = acc;
  end

endmodule

// File: rtl/flip_alpha_gen.sv
// Scans a codeword's reliabilities for the two weakest positions and produces
// alpha^(m*pos) for m = 1,3,5,7 for each, held until the consumer releases it.
module flip_alpha_gen
  import flip_alpha_gen_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_code,
  input  logic       i_in_valid,
  input  logic [6:0] i_in_rel,
  input  logic       i_in_last,
  output logic       o_in_ready,
  input  logic       i_release,
  output logic [9:0] o_pos1,
  output logic [9:0] o_pos2,
  output logic [9:0] o_flip_alpha_S1_1,
  output logic [9:0] o_flip_alpha_S3_1,
  output logic [9:0] o_flip_alpha_S5_1,
  output logic [9:0] o_flip_alpha_S7_1,
  output logic [9:0] o_flip_alpha_S1_2,
  output logic [9:0] o_flip_alpha_S3_2,
  output logic [9:0] o_flip_alpha_S5_2,
  output logic [9:0] o_flip_alpha_S7_2,
  output logic       o_flip_alpha_valid
);

  state_t     state;
  logic [1:0] code_q, step, hold_cnt;
  logic       rel_pend;
  logic [9:0] k, a_run;
  logic [7:0] min1, min2;
  logic [9:0] idx1, idx2, alpha1, alpha2, x2_1, x2_2;

  logic       first, accept, frame_end;
  logic [1:0] cur_code;
  logic [9:0] cur_a, cur_idx1, cur_alpha1;
  logic [7:0] cur_min1, cur_min2, rel_ext;
  logic [9:0] ma1, mb1, mp1, ma2, mb2, mp2;

  // The first sample of a frame sees freshly cleared minima and a_run = 1.
  assign first      = (k == 10'd0);
  assign cur_code   = first ? i_code : code_q;
  assign cur_a      = first ? 10'd1 : a_run;
  assign cur_min1   = first ? 8'h80 : min1;
  assign cur_min2   = first ? 8'h80 : min2;
  assign cur_idx1   = first ? 10'd0 : idx1;
  assign cur_alpha1 = first ? 10'd0 : alpha1;
  assign rel_ext    = {1'b0, i_in_rel};
  assign o_in_ready = (state == SCAN);
  assign accept     = i_in_valid && o_in_ready;
  assign frame_end  = i_in_last || (k == code_n(cur_code) - 10'd1);

  // Operand routing for the x2, x3, x5, x7 power chain.
  always_comb begin
    ma1 = alpha1; mb1 = alpha1;
    ma2 = alpha2; mb2 = alpha2;
    case (step)
      2'd1: begin ma1 = x2_1; ma2 = x2_2; end
      2'd2: begin
        ma1 = o_flip_alpha_S3_1; mb1 = x2_1;
        ma2 = o_flip_alpha_S3_2; mb2 = x2_2;
      end
      2'd3: begin
        ma1 = o_flip_alpha_S5_1; mb1 = x2_1;
        ma2 = o_flip_alpha_S5_2; mb2 = x2_2;
      end
      default: ;
    endcase
  end

  gf_mult u_mult1 (.code(code_q), .a(ma1), .b(mb1), .p(mp1));
  gf_mult u_mult2 (.code(code_q), .a(ma2), .b(mb2), .p(mp2));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= SCAN; code_q <= CODE_GF6; step <= '0; hold_cnt <= '0; rel_pend <= 1'b0;
      k <= '0; a_run <= '0; min1 <= 8'h80; min2 <= 8'h80;
      idx1 <= '0; idx2 <= '0; alpha1 <= '0; alpha2 <= '0; x2_1 <= '0; x2_2 <= '0;
      o_pos1 <= '0; o_pos2 <= '0; o_flip_alpha_valid <= 1'b0;
      o_flip_alpha_S1_1 <= '0; o_flip_alpha_S3_1 <= '0;
      o_flip_alpha_S5_1 <= '0; o_flip_alpha_S7_1 <= '0;
      o_flip_alpha_S1_2 <= '0; o_flip_alpha_S3_2 <= '0;
      o_flip_alpha_S5_2 <= '0; o_flip_alpha_S7_2 <= '0;
    end else begin
      case (state)
        SCAN: if (accept) begin
          code_q <= cur_code;
          min1   <= cur_min1;
          min2   <= cur_min2;
          if (rel_ext < cur_min1) begin
            min2 <= cur_min1; idx2 <= cur_idx1; alpha2 <= cur_alpha1;
            min1 <= rel_ext;  idx1 <= k;        alpha1 <= cur_a;
          end else if (rel_ext < cur_min2) begin
            min2 <= rel_ext;  idx2 <= k;        alpha2 <= cur_a;
          end
          a_run <= gf_mul_alpha(cur_code, cur_a);
          if (frame_end) begin
            k <= '0; step <= '0; state <= POW;
          end else begin
            k <= k + 10'd1;
          end
        end
        POW: begin
          step <= step + 2'd1;
          case (step)
            2'd0: begin
              x2_1 <= mp1; x2_2 <= mp2; o_pos1 <= idx1; o_pos2 <= idx2;
              o_flip_alpha_S1_1 <= alpha1; o_flip_alpha_S1_2 <= alpha2;
            end
            2'd1: begin o_flip_alpha_S3_1 <= mp1; o_flip_alpha_S3_2 <= mp2; end
            2'd2: begin o_flip_alpha_S5_1 <= mp1; o_flip_alpha_S5_2 <= mp2; end
            default: begin
              o_flip_alpha_S7_1 <= mp1; o_flip_alpha_S7_2 <= mp2;
              o_flip_alpha_valid <= 1'b1; hold_cnt <= '0; rel_pend <= 1'b0;
              state <= HOLD;
            end
          endcase
        end
        HOLD: begin
          // A release arriving before the minimum hold time is remembered, not lost.
          if (hold_cnt != 2'd3) begin
            hold_cnt <= hold_cnt + 2'd1;
            if (i_release) rel_pend <= 1'b1;
          end else if (i_release || rel_pend) begin
            o_flip_alpha_valid <= 1'b0;
            state <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_flip_alpha_gen.sv
// Scoreboard bench for flip_alpha_gen: stimulus pushes model results, a monitor
// pops and checks them when valid rises, then exercises hold and release.
module tb_flip_alpha_gen;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [1:0] i_code;
  logic       i_in_valid;
  logic [6:0] i_in_rel;
  logic       i_in_last;
  logic       o_in_ready;
  logic       i_release;
  logic [9:0] o_pos1, o_pos2;
  logic [9:0] o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1, o_flip_alpha_S7_1;
  logic [9:0] o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2, o_flip_alpha_S7_2;
  logic       o_flip_alpha_valid;

  flip_alpha_gen dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_code(i_code), .i_in_valid(i_in_valid),
    .i_in_rel(i_in_rel), .i_in_last(i_in_last), .o_in_ready(o_in_ready),
    .i_release(i_release), .o_pos1(o_pos1), .o_pos2(o_pos2),
    .o_flip_alpha_S1_1(o_flip_alpha_S1_1), .o_flip_alpha_S3_1(o_flip_alpha_S3_1),
    .o_flip_alpha_S5_1(o_flip_alpha_S5_1), .o_flip_alpha_S7_1(o_flip_alpha_S7_1),
    .o_flip_alpha_S1_2(o_flip_alpha_S1_2), .o_flip_alpha_S3_2(o_flip_alpha_S3_2),
    .o_flip_alpha_S5_2(o_flip_alpha_S5_2), .o_flip_alpha_S7_2(o_flip_alpha_S7_2),
    .o_flip_alpha_valid(o_flip_alpha_valid)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc = cyc + 1;

  typedef struct {
    logic [99:0] vals;
    int          last_cyc;
    int          hold;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_busy = 1'b0;
  logic [6:0] rel_mem [1024];
  int         exp_tab [1023];
  string      fname [10] = '{"pos1", "pos2", "S1_1", "S3_1", "S5_1", "S7_1",
                              "S1_2", "S3_2", "S5_2", "S7_2"};

  function automatic logic [99:0] packAct();
    return {o_pos1, o_pos2, o_flip_alpha_S1_1, o_flip_alpha_S3_1, o_flip_alpha_S5_1,
            o_flip_alpha_S7_1, o_flip_alpha_S1_2, o_flip_alpha_S3_2, o_flip_alpha_S5_2,
            o_flip_alpha_S7_2};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nOf(input int code);
    return (code == 0) ? 63 : (code == 1) ? 255 : 1023;
  endfunction

  // Reference: alpha power table from the full polynomial, minima by direct search.
  function automatic exp_t computeExpected(input int code, input int len, input int hold);
    exp_t e;
    int n, m, poly, v, p1, p2, best;
    int pw [4] = '{1, 3, 5, 7};
    n    = nOf(code);
    m    = (code == 0) ? 6 : (code == 1) ? 8 : 10;
    poly = (code == 0) ? 'h43 : (code == 1) ? 'h11D : 'h409;
    v = 1;
    for (int i = 0; i < n; i++) begin
      exp_tab[i] = v;
      v = v * 2;
      if (v >= (1 << m)) v = v ^ poly;
    end
    if (len > n) len = n;
    best = 1000; p1 = 0;
    for (int i = 0; i < len; i++) if (int'(rel_mem[i]) < best) begin best = rel_mem[i]; p1 = i; end
    best = 1000; p2 = 0;
    for (int i = 0; i < len; i++)
      if (i != p1 && int'(rel_mem[i]) < best) begin best = rel_mem[i]; p2 = i; end
    e.vals[99:90] = p1[9:0];
    e.vals[89:80] = p2[9:0];
    for (int j = 0; j < 4; j++) begin
      v = exp_tab[(pw[j] * p1) % n];
      e.vals[79 - 10*j -: 10] = v[9:0];
      v = exp_tab[(pw[j] * p2) % n];
      e.vals[39 - 10*j -: 10] = v[9:0];
    end
    e.last_cyc = 0;
    e.hold     = hold;
    return e;
  endfunction

  task automatic applyStimulus(input int code, input int len, input bit use_last,
                               input bit keep_valid, input bit push, input int hold);
    exp_t e;
    int guard;
    e = computeExpected(code, len, hold);
    for (int k = 0; k < len; k++) begin
      i_code     = code[1:0];
      i_in_valid = 1'b1;
      i_in_rel   = rel_mem[k];
      i_in_last  = use_last && (k == len - 1);
      guard = 0;
      while (!o_in_ready) begin
        @(negedge i_clk);
        guard++;
        if (guard > 200) begin
          $display("[TB] FAIL ready_timeout: got ready 0, expected 1 within 200 cycles");
          $fatal(1, "[TB] stalled");
        end
      end
      @(negedge i_clk);
    end
    if (!keep_valid) begin
      i_in_valid = 1'b0;
      i_in_last  = 1'b0;
    end
    if (push) begin
      e.last_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic fillRandom(input int lo, input int hi);
    for (int i = 0; i < 1024; i++) rel_mem[i] = 7'($urandom_range(hi, lo));
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((sb.size() != 0 || mon_busy) && guard < 3000) begin
      @(negedge i_clk);
      guard++;
    end
    checkOutput("idle_timeout", guard < 3000, 1);
  endtask

  // Monitor: pop on valid rise, check hold stability, then release.
  initial begin
    exp_t e;
    bit prev_v = 1'b0;
    i_release = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_flip_alpha_valid && !prev_v) begin
        mon_busy = 1'b1;
        if (sb.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < 10; i++)
            checkOutput(fname[i], int'(packAct() >> (90 - 10*i)) & 'h3FF,
                        int'(e.vals >> (90 - 10*i)) & 'h3FF);
          checkOutput("latency", cyc - e.last_cyc, 4);
          for (int h = 0; h < e.hold; h++) begin
            @(negedge i_clk);
            checkOutput("hold_stable", {o_flip_alpha_valid, o_in_ready, packAct()} ==
                        {1'b1, 1'b0, e.vals}, 1);
          end
          i_release = 1'b1;
          @(negedge i_clk);
          i_release = 1'b0;
          checkOutput("release_valid", o_flip_alpha_valid, 0);
          checkOutput("release_ready", o_in_ready, 1);
        end
        mon_busy = 1'b0;
      end
      prev_v = o_flip_alpha_valid;
    end
  end

  initial begin
    i_rst_n = 1'b0; i_code = 2'b00; i_in_valid = 1'b0; i_in_rel = '0; i_in_last = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_outputs", packAct() == 100'd0, 1);
    checkOutput("reset_valid", o_flip_alpha_valid, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("reset_ready", o_in_ready, 1);

    for (int i = 0; i < 1024; i++) rel_mem[i] = 7'd50;
    rel_mem[1] = 7'd3; rel_mem[6] = 7'd7;
    applyStimulus(0, 63, 1'b1, 1'b0, 1'b1, 4);

    for (int i = 0; i < 1024; i++) rel_mem[i] = 7'd20;
    applyStimulus(1, 255, 1'b1, 1'b0, 1'b1, 4);

    for (int i = 0; i < 1024; i++) rel_mem[i] = 7'd100;
    rel_mem[1022] = 7'd0; rel_mem[0] = 7'd1;
    applyStimulus(2, 1023, 1'b0, 1'b0, 1'b1, 4);

    // Long hold with valid pressed on, then back-to-back frames needing fresh minima.
    fillRandom(0, 10);
    applyStimulus(0, 40, 1'b1, 1'b1, 1'b1, 10);
    fillRandom(60, 127);
    applyStimulus(1, 200, 1'b1, 1'b1, 1'b1, 4);
    fillRandom(0, 7);
    applyStimulus(0, 63, 1'b0, 1'b0, 1'b1, 5);
    waitIdle();

    fillRandom(0, 127);
    applyStimulus(1, 100, 1'b1, 1'b0, 1'b0, 4);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checkOutput("midpow_reset_outputs", packAct() == 100'd0, 1);
    checkOutput("midpow_reset_valid", o_flip_alpha_valid, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("midpow_reset_ready", o_in_ready, 1);
    fillRandom(30, 90);
    applyStimulus(1, 120, 1'b1, 1'b0, 1'b1, 4);

    for (int f = 0; f < 6; f++) begin
      int code, len;
      code = $urandom_range(2, 0);
      len  = $urandom_range(nOf(code), 2);
      if (f % 2 == 0) fillRandom(0, 7); else fillRandom(0, 127);
      applyStimulus(code, len, 1'b1, f != 5, 1'b1, $urandom_range(8, 4));
    end
    waitIdle();
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
